// File: rtl/pdp8_tty.sv
// pdp8_tty: PDP-8 console teletype (keyboard dev 03, printer dev 04) on an 8N1 UART.
// Define TT_KIE_EN to decode 6035 as KIE (interrupt enable from AC[0]).
module pdp8_tty #(
  parameter logic [3:0] EXEC_STATE = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        brgclk,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic        io_selected,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  input  logic        uart_in,
  output logic        uart_out
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic       kbd, tto, kie, ie, exec, exec_d, commit, send, rx_set, tx_set;
  logic       kbd_flag, tto_flag, rx_prev;
  logic [1:0] rx_s, rx_st, tx_st;
  logic [3:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_sh, rxbuf, tx_sh;
  logic       unused;
  assign unused = ^{mb[11:3], io_data_in[11:8]};
  assign kbd = iot & (io_select == 6'o03);
  assign tto = iot & (io_select == 6'o04);
  assign exec = iot & (state == EXEC_STATE);
  // Side effects fire once per IOT, on the first exec cycle only
  assign commit = exec & ~exec_d;
  assign send = commit & tto & mb[2];
`ifdef TT_KIE_EN
  assign kie = kbd & (mb[2:0] == 3'b101);
  always_ff @(posedge clk or posedge reset)
    if (reset) ie <= 1'b1;
    else if (commit & kie) ie <= io_data_in[0];
`else
  assign kie = 1'b0;
  assign ie = 1'b1;
`endif
  assign io_selected = kbd | tto;
  assign io_skip = mb[0] & ((kbd & ~kie & kbd_flag) | (tto & tto_flag));
  assign io_data_avail = kbd & ~kie & (mb[1] | mb[2]);
  assign io_data_out = (kbd & ~kie & mb[2]) ? {4'b0, rxbuf} : 12'd0;
  assign io_interrupt = ie & (kbd_flag | tto_flag);
  assign rx_set = (rx_st == STOP) & brgclk & (rx_cnt == 4'd15) & rx_s[1];
  assign tx_set = (tx_st == STOP) & brgclk & (tx_cnt == 4'd15);
  always_ff @(posedge clk or posedge reset)
    if (reset) exec_d <= 1'b0;
    else exec_d <= exec;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s     <= 2'b11;
      rx_prev  <= 1'b1;
      rx_st    <= IDLE;
      rx_cnt   <= 4'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
      rxbuf    <= 8'd0;
      kbd_flag <= 1'b0;
    end else begin
      rx_s    <= {rx_s[0], uart_in};
      rx_prev <= rx_s[1];
      if (rx_set) kbd_flag <= 1'b1;
      else if (commit & kbd & mb[1] & ~kie) kbd_flag <= 1'b0;
      case (rx_st)
        IDLE: if (rx_prev & ~rx_s[1]) begin
          rx_st  <= START;
          rx_cnt <= 4'd0;
        end
        START: if (brgclk) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd7) begin
            rx_st  <= rx_s[1] ? IDLE : DATA;
            rx_cnt <= 4'd0;
            rx_bit <= 3'd0;
          end
        end
        DATA: if (brgclk) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_sh  <= {rx_s[1], rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= STOP;
          end
        end
        STOP: if (brgclk) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_st <= IDLE;
            if (rx_s[1]) rxbuf <= rx_sh;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st    <= IDLE;
      tx_cnt   <= 4'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      uart_out <= 1'b1;
      tto_flag <= 1'b0;
    end else begin
      if (tx_set) tto_flag <= 1'b1;
      else if (commit & tto & mb[1]) tto_flag <= 1'b0;
      case (tx_st)
        IDLE: if (send) begin
          tx_sh    <= io_data_in[7:0];
          tx_st    <= START;
          tx_cnt   <= 4'd0;
          uart_out <= 1'b0;
        end
        START: if (brgclk) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            tx_st    <= DATA;
            tx_bit   <= 3'd0;
            uart_out <= tx_sh[0];
          end
        end
        DATA: if (brgclk) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            uart_out <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
            if (tx_bit == 3'd7) tx_st <= STOP;
          end
        end
        STOP: if (brgclk) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) tx_st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pdp8_tty.sv
// tb_pdp8_tty: scoreboard bench for the console teletype, 4 clk per baud tick (64 clk per bit).
module tb_pdp8_tty;
  logic        clk, reset, brgclk, iot, uart_in;
  logic [3:0]  state;
  logic [11:0] mb, io_data_in, io_data_out;
  logic [5:0]  io_select;
  logic        io_selected, io_data_avail, io_interrupt, io_skip, uart_out;
  logic        o_skip, o_avail, o_sel;
  logic [11:0] o_dout;
  logic [11:0] rx_q[$];
  logic        tx_q[$];
  logic [11:0] last_rx;
  int          checks, errors;

  pdp8_tty dut (
    .clk(clk), .reset(reset), .brgclk(brgclk), .iot(iot), .state(state), .mb(mb),
    .io_select(io_select), .io_data_in(io_data_in), .io_selected(io_selected),
    .io_data_out(io_data_out), .io_data_avail(io_data_avail), .io_interrupt(io_interrupt),
    .io_skip(io_skip), .uart_in(uart_in), .uart_out(uart_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    brgclk = 0;
    forever begin
      repeat (3) @(negedge clk);
      brgclk = 1;
      @(negedge clk);
      brgclk = 0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_iot(input logic [5:0] dev, input logic [2:0] ops, input logic [11:0] ac);
    @(negedge clk);
    iot = 1; io_select = dev; mb = {3'o6, dev, ops}; io_data_in = ac; state = 4'd1;
    #1;
    o_skip = io_skip; o_dout = io_data_out; o_avail = io_data_avail; o_sel = io_selected;
    @(negedge clk);
    iot = 0; io_select = 0; mb = 0; state = 0;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    if (stop) rx_q.push_back({4'b0, b});
    uart_in = 0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (64) @(negedge clk);
    end
    uart_in = stop;
    repeat (64) @(negedge clk);
    uart_in = 1;
    repeat (64) @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  task automatic tx_monitor();
    int  n = 0;
    logic e;
    while (uart_out !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (uart_out !== 1'b0) begin
      checks++; errors++;
      $display("FAIL tx_start timeout uart_out=%b want 0", uart_out);
      tx_q.delete();
      return;
    end
    repeat (32) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      e = tx_q.pop_front();
      checks++;
      if (uart_out !== e) begin
        errors++;
        $display("FAIL tx_bit%0d got %b want %b", i, uart_out, e);
      end
      if (i < 9) repeat (64) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1; iot = 0; state = 0; mb = 0; io_select = 0; io_data_in = 0; uart_in = 1;
    repeat (3) @(negedge clk);
    checks++; if (uart_out !== 1'b1) begin errors++; $display("FAIL reset_uart_out got %b want 1", uart_out); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", io_interrupt); end
    checks++; if ({io_selected, io_skip, io_data_avail, io_data_out} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {io_selected, io_skip, io_data_avail, io_data_out}); end
    reset = 0;
    last_rx = 0;
    do_iot(6'o03, 3'b001, 0);
    checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL reset_ksf_skip got %b want 0", o_skip); end
    checks++; if (o_sel !== 1'b1) begin errors++; $display("FAIL ksf_selected got %b want 1", o_sel); end
    do_iot(6'o05, 3'b111, 0);
    checks++; if ({o_sel, o_avail, o_dout} !== 14'd0) begin errors++; $display("FAIL other_dev got %h want 0", {o_sel, o_avail, o_dout}); end
  endtask

  task automatic test_rx();
    logic [11:0] e;
    uart_send(8'h41, 1'b1);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL rx_irq got %b want 1", io_interrupt); end
    do_iot(6'o03, 3'b001, 0);
    checks++; if (o_skip !== 1'b1) begin errors++; $display("FAIL rx_ksf got %b want 1", o_skip); end
`ifdef TT_KIE_EN
    do_iot(6'o03, 3'b101, 12'd0);
    checks++; if ({o_skip, o_avail} !== 2'b00) begin errors++; $display("FAIL kie_decode got %b want 00", {o_skip, o_avail}); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL kie_off_irq got %b want 0", io_interrupt); end
    do_iot(6'o03, 3'b101, 12'd1);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL kie_on_irq got %b want 1", io_interrupt); end
`else
    do_iot(6'o03, 3'b101, 0);
    checks++; if ({o_skip, o_avail, o_dout} !== {2'b11, 12'o0101}) begin
      errors++; $display("FAIL op6035 got %b%b %o want 11 0101", o_skip, o_avail, o_dout); end
`endif
    do_iot(6'o03, 3'b110, 0);
    e = rx_q.pop_front();
    last_rx = e;
    checks++; if (o_dout !== e) begin errors++; $display("FAIL krb_data got %o want %o", o_dout, e); end
    checks++; if (o_avail !== 1'b1) begin errors++; $display("FAIL krb_avail got %b want 1", o_avail); end
    do_iot(6'o03, 3'b001, 0);
    checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL krb_clears got %b want 0", o_skip); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL krb_irq got %b want 0", io_interrupt); end
  endtask

  task automatic test_framing();
    uart_send(8'h55, 1'b0);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL frame_irq got %b want 0", io_interrupt); end
    do_iot(6'o03, 3'b100, 0);
    checks++; if (o_dout !== last_rx) begin errors++; $display("FAIL frame_rxbuf got %o want %o", o_dout, last_rx); end
    do_iot(6'o03, 3'b001, 0);
    checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL frame_flag got %b want 0", o_skip); end
  endtask

  task automatic test_tx();
    push_frame(8'o132);
    fork
      do_iot(6'o04, 3'b110, 12'o0132);
      tx_monitor();
    join
    checks++; if (o_avail !== 1'b0) begin errors++; $display("FAIL tls_avail got %b want 0", o_avail); end
    do_iot(6'o04, 3'b001, 0);
    checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL tsf_early got %b want 0", o_skip); end
    repeat (40) @(negedge clk);
    do_iot(6'o04, 3'b001, 0);
    checks++; if (o_skip !== 1'b1) begin errors++; $display("FAIL tsf_done got %b want 1", o_skip); end
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL tx_irq got %b want 1", io_interrupt); end
    do_iot(6'o04, 3'b010, 0);
    do_iot(6'o04, 3'b001, 0);
    checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL tcf got %b want 0", o_skip); end
  endtask

  task automatic test_back_to_back();
    push_frame(8'h33);
    fork
      do_iot(6'o04, 3'b100, 12'h033);
      tx_monitor();
    join
    repeat (40) @(negedge clk);
    push_frame(8'hC3);
    fork
      begin
        do_iot(6'o04, 3'b100, 12'h0C3);
        do_iot(6'o04, 3'b001, 0);
        checks++; if (o_skip !== 1'b1) begin errors++; $display("FAIL tpc_keeps_flag got %b want 1", o_skip); end
        repeat (200) @(negedge clk);
        do_iot(6'o04, 3'b100, 12'h0FF);
        repeat (100) @(negedge clk);
        do_iot(6'o04, 3'b110, 12'h000);
        do_iot(6'o04, 3'b001, 0);
        checks++; if (o_skip !== 1'b0) begin errors++; $display("FAIL busy_tls_clear got %b want 0", o_skip); end
      end
      tx_monitor();
    join
    repeat (40) @(negedge clk);
    do_iot(6'o04, 3'b001, 0);
    checks++; if (o_skip !== 1'b1) begin errors++; $display("FAIL b2b_flag got %b want 1", o_skip); end
  endtask

  task automatic test_reset_abort();
    do_iot(6'o04, 3'b110, 12'h000);
    repeat (100) @(negedge clk);
    checks++; if (uart_out !== 1'b0) begin errors++; $display("FAIL abort_pre got %b want 0", uart_out); end
    reset = 1;
    #1;
    checks++; if (uart_out !== 1'b1) begin errors++; $display("FAIL abort_uart got %b want 1", uart_out); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL abort_irq got %b want 0", io_interrupt); end
    @(negedge clk);
    reset = 0;
    do_iot(6'o03, 3'b100, 0);
    checks++; if (o_dout !== 12'd0) begin errors++; $display("FAIL abort_rxbuf got %o want 0", o_dout); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_rx();
    test_framing();
    test_tx();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
